// File: rtl/clk_domain_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_domain_rst_seq
// Power-up / lock-loss reset sequencer for the display clock tree.
// Waits for a stable PLL lock, then releases the domain resets in the fixed
// order data -> output -> core with programmable gaps. A lock drop or a soft
// re-init reasserts all three domain resets on the same edge.
//
// Ports
//   clk_c_0    in   controller clock, rising edge
//   rst        in   synchronous active-high reset
//   pll_lock   in   PLL lock flag (asynchronous, synchronized here)
//   reinit     in   soft re-init request
//   rst_data   out  data domain reset (active high)
//   rst_out    out  output domain reset (active high)
//   rst_core   out  core domain reset (active high)
//   sys_ready  out  high only in RUN
//   lock_lost  out  one-cycle pulse per counted lock drop
//   loss_count out  saturating count of lock drops
//   state      out  FSM state code (debug)
// ---------------------------------------------------------------------------
module clk_domain_rst_seq #(
    parameter int LOCK_WAIT = 16,
    parameter int STAGE_GAP = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk_c_0,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             reinit,
    output logic             rst_data,
    output logic             rst_out,
    output logic             rst_core,
    output logic             sys_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_REL_D     = 3'd3,
        S_REL_O     = 3'd4,
        S_RUN       = 3'd5
    } state_t;

    localparam int MAX_WAIT = (LOCK_WAIT > STAGE_GAP) ? LOCK_WAIT : STAGE_GAP;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_WAIT - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_GAP - 1);

    logic [1:0]       sync_reg;
    logic             lock_s;
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             drop;
    logic             rst_data_reg, rst_data_next;
    logic             rst_out_reg, rst_out_next;
    logic             rst_core_reg, rst_core_next;
    logic             sys_ready_reg, sys_ready_next;
    logic             lock_lost_reg, lock_lost_next;
    logic [CNT_W-1:0] loss_count_reg, loss_count_next;

    assign lock_s = sync_reg[1];

    // State register: synchronizer, FSM state, counter and all registered outputs.
    always_ff @(posedge clk_c_0) begin
        if (rst) begin
            sync_reg       <= 2'b00;
            state_reg      <= S_RESET;
            cnt_reg        <= '0;
            rst_data_reg   <= 1'b1;
            rst_out_reg    <= 1'b1;
            rst_core_reg   <= 1'b1;
            sys_ready_reg  <= 1'b0;
            lock_lost_reg  <= 1'b0;
            loss_count_reg <= '0;
        end else begin
            sync_reg       <= {sync_reg[0], pll_lock};
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rst_data_reg   <= rst_data_next;
            rst_out_reg    <= rst_out_next;
            rst_core_reg   <= rst_core_next;
            sys_ready_reg  <= sys_ready_next;
            lock_lost_reg  <= lock_lost_next;
            loss_count_reg <= loss_count_next;
        end
    end

    // Next-state logic. A lock drop in any locked state outranks reinit so a
    // coincident reinit still gets the drop counted.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        drop       = 1'b0;
        case (state_reg)
            S_RESET: begin
                state_next = S_WAIT_LOCK;
                cnt_next   = '0;
            end
            S_WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s && !reinit) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_reg == LOCK_LAST) begin
                    state_next = S_REL_D;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_REL_D: begin
                if (cnt_reg == STAGE_LAST) begin
                    state_next = S_REL_O;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_REL_O: begin
                if (cnt_reg == STAGE_LAST) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = S_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        if ((state_reg == S_SETTLE || state_reg == S_REL_D ||
             state_reg == S_REL_O  || state_reg == S_RUN) && !lock_s) begin
            drop       = 1'b1;
            state_next = S_WAIT_LOCK;
            cnt_next   = '0;
        end else if (state_reg != S_RESET && reinit) begin
            state_next = S_WAIT_LOCK;
            cnt_next   = '0;
        end
    end

    // Output logic: registered outputs follow the state being entered, so
    // every reset changes on the same edge as the state transition.
    always_comb begin
        rst_data_next   = 1'b1;
        rst_out_next    = 1'b1;
        rst_core_next   = 1'b1;
        sys_ready_next  = 1'b0;
        lock_lost_next  = drop;
        loss_count_next = loss_count_reg;
        case (state_next)
            S_REL_D: begin
                rst_data_next = 1'b0;
            end
            S_REL_O: begin
                rst_data_next = 1'b0;
                rst_out_next  = 1'b0;
            end
            S_RUN: begin
                rst_data_next  = 1'b0;
                rst_out_next   = 1'b0;
                rst_core_next  = 1'b0;
                sys_ready_next = 1'b1;
            end
            default: begin
                rst_data_next = 1'b1;
            end
        endcase
        if (drop && !(&loss_count_reg)) begin
            loss_count_next = loss_count_reg + 1'b1;
        end
    end

    assign rst_data   = rst_data_reg;
    assign rst_out    = rst_out_reg;
    assign rst_core   = rst_core_reg;
    assign sys_ready  = sys_ready_reg;
    assign lock_lost  = lock_lost_reg;
    assign loss_count = loss_count_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_clk_domain_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_domain_rst_seq
// Directed bench for clk_domain_rst_seq. A table of {inputs held for N edges,
// expected outputs} records drives the main flow; a hand-written sequence
// then measures the exact release edges after power-up. A second instance
// with a 2-bit loss counter shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_clk_domain_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       reinit;
    logic       rst_data, rst_out, rst_core, sys_ready, lock_lost;
    logic [7:0] loss_count;
    logic [2:0] state;
    logic       rst_data2, rst_out2, rst_core2, sys_ready2, lock_lost2;
    logic [1:0] loss_count2;
    logic [2:0] state2;

    int n_tests;
    int n_fail;

    clk_domain_rst_seq #(.LOCK_WAIT(16), .STAGE_GAP(4), .CNT_W(8)) dut (
        .clk_c_0(clk), .rst(rst), .pll_lock(pll_lock), .reinit(reinit),
        .rst_data(rst_data), .rst_out(rst_out), .rst_core(rst_core),
        .sys_ready(sys_ready), .lock_lost(lock_lost),
        .loss_count(loss_count), .state(state)
    );

    clk_domain_rst_seq #(.LOCK_WAIT(16), .STAGE_GAP(4), .CNT_W(2)) dut2 (
        .clk_c_0(clk), .rst(rst), .pll_lock(pll_lock), .reinit(reinit),
        .rst_data(rst_data2), .rst_out(rst_out2), .rst_core(rst_core2),
        .sys_ready(sys_ready2), .lock_lost(lock_lost2),
        .loss_count(loss_count2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       reinit;
        int         cyc;
        logic [2:0] st;
        logic       ll;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic ri, input int c,
                       input logic [2:0] s, input logic ll, input int cnt);
        vec_t v;
        v.rst = r; v.lock = l; v.reinit = ri; v.cyc = c;
        v.st = s; v.ll = ll; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Expected {rst_data, rst_out, rst_core, sys_ready} for each state code.
    function automatic logic [3:0] exp_outs(input logic [2:0] s);
        case (s)
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0010;
            3'd5:    return 4'b0001;
            default: return 4'b1110;
        endcase
    endfunction

    initial begin
        logic [19:0] act, exp;
        logic [1:0]  cnt2_exp;
        int t_d, t_o, t_c, t_r;

        rst = 1'b1; pll_lock = 1'b0; reinit = 1'b0;
        n_tests = 0; n_fail = 0;

        // Reset and idle without lock
        add(1,0,0,2, 3'd0,0,0);
        add(0,0,0,1, 3'd1,0,0);
        add(0,0,0,3, 3'd1,0,0);
        // Power-up: E = 2 edges after first sample of lock
        add(0,1,0,2, 3'd1,0,0);
        add(0,1,0,1, 3'd2,0,0);
        add(0,1,0,15,3'd2,0,0);
        add(0,1,0,1, 3'd3,0,0);
        add(0,1,0,3, 3'd3,0,0);
        add(0,1,0,1, 3'd4,0,0);
        add(0,1,0,3, 3'd4,0,0);
        add(0,1,0,1, 3'd5,0,0);
        add(0,1,0,5, 3'd5,0,0);
        // One-cycle lock drop in RUN, then full resequence
        add(0,0,0,1, 3'd5,0,0);
        add(0,1,0,1, 3'd5,0,0);
        add(0,1,0,1, 3'd1,1,1);
        add(0,1,0,1, 3'd2,0,1);
        add(0,1,0,15,3'd2,0,1);
        add(0,1,0,1, 3'd3,0,1);
        add(0,1,0,4, 3'd4,0,1);
        add(0,1,0,4, 3'd5,0,1);
        // reinit in RUN: not counted
        add(0,1,1,1, 3'd1,0,1);
        add(0,1,0,1, 3'd2,0,1);
        // Glitch seen at counter==10 in SETTLE, full LOCK_WAIT restarts
        add(0,1,0,8, 3'd2,0,1);
        add(0,0,0,1, 3'd2,0,1);
        add(0,1,0,1, 3'd2,0,1);
        add(0,1,0,1, 3'd1,1,2);
        add(0,1,0,1, 3'd2,0,2);
        add(0,1,0,15,3'd2,0,2);
        add(0,1,0,1, 3'd3,0,2);
        // Lock drop and reinit on the same edge in REL_D: counted once
        add(0,0,0,1, 3'd3,0,2);
        add(0,1,0,1, 3'd3,0,2);
        add(0,1,1,1, 3'd1,1,3);
        add(0,1,1,2, 3'd1,0,3);
        add(0,1,0,1, 3'd2,0,3);
        add(0,1,0,15,3'd2,0,3);
        add(0,1,0,1, 3'd3,0,3);
        add(0,1,0,4, 3'd4,0,3);
        // rst in REL_O clears everything incl. the synchronizer
        add(1,1,0,1, 3'd0,0,0);
        add(0,1,0,1, 3'd1,0,0);
        add(0,1,0,1, 3'd1,0,0);
        add(0,1,0,1, 3'd2,0,0);
        // Five lock drops: 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            add(0,0,0,1, 3'd2,0,i-1);
            add(0,1,0,1, 3'd2,0,i-1);
            add(0,1,0,1, 3'd1,1,i);
            add(0,1,0,1, 3'd2,0,i);
        end

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; pll_lock = vecs[i].lock; reinit = vecs[i].reinit;
            repeat (vecs[i].cyc) @(posedge clk);
            #1;
            cnt2_exp = (vecs[i].cnt > 3) ? 2'd3 : vecs[i].cnt[1:0];
            act = {state, rst_data, rst_out, rst_core, sys_ready, lock_lost,
                   loss_count, loss_count2, lock_lost2};
            exp = {vecs[i].st, exp_outs(vecs[i].st), vecs[i].ll,
                   vecs[i].cnt[7:0], cnt2_exp, vecs[i].ll};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("[TB] FAIL vec%0d {st,rd,ro,rc,rdy,ll,cnt,cnt2,ll2} got=%b want=%b",
                         i, act, exp);
            end else begin
                $display("[TB] vec%0d st=%0d rd=%b ro=%b rc=%b rdy=%b ll=%b cnt=%0d cnt2=%0d ok",
                         i, state, rst_data, rst_out, rst_core, sys_ready, lock_lost,
                         loss_count, loss_count2);
            end
        end

        // Hand-written: exact release edges counted from the first edge
        // that samples pll_lock high (edge 1): E = edge 3.
        rst = 1'b1; pll_lock = 1'b0; reinit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 pll_lock = 1'b1;
        t_d = 0; t_o = 0; t_c = 0; t_r = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (t_d == 0 && rst_data == 1'b0)  t_d = e;
            if (t_o == 0 && rst_out == 1'b0)   t_o = e;
            if (t_c == 0 && rst_core == 1'b0)  t_c = e;
            if (t_r == 0 && sys_ready == 1'b1) t_r = e;
        end
        n_tests++;
        if (t_d != 19) begin
            n_fail++; $display("[TB] FAIL rst_data_release edge got=%0d want=19", t_d);
        end else $display("[TB] rst_data released at edge %0d ok", t_d);
        n_tests++;
        if (t_o != 23) begin
            n_fail++; $display("[TB] FAIL rst_out_release edge got=%0d want=23", t_o);
        end else $display("[TB] rst_out released at edge %0d ok", t_o);
        n_tests++;
        if (t_c != 27) begin
            n_fail++; $display("[TB] FAIL rst_core_release edge got=%0d want=27", t_c);
        end else $display("[TB] rst_core released at edge %0d ok", t_c);
        n_tests++;
        if (t_r != 27) begin
            n_fail++; $display("[TB] FAIL sys_ready_rise edge got=%0d want=27", t_r);
        end else $display("[TB] sys_ready rose at edge %0d ok", t_r);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
